// File: rtl/fp13_pkg.sv
// Shared types and constants for the 13-bit sign-magnitude float datapath.
package fp13_pkg;

  localparam int EXP_W = 4;
  localparam int SIG_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 4'hF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp13_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } fp13_add_state_e;

  // A zero significand has one representation: +0 with exponent 0.
  function automatic fp13_t fp13_canon(input fp13_t x);
    fp13_t r;
    r = x;
    if (x.sig == '0) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/fp13_lzc.sv
// 8-bit leading-zero counter; an all-zero input reports 8.
module fp13_lzc
  import fp13_pkg::*;
(
  input  logic [SIG_W-1:0] val,
  output logic [3:0]       cnt
);

  always_comb begin
    cnt = 4'd8;
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < SIG_W; i++) begin
      if (val[i]) cnt = 4'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp13_adder.sv
// Sequential fp13 adder: align, add/subtract, normalize; valid/ready on both sides.
// Define FP13_ADDER_LZC_EN to normalize in one cycle with a leading-zero count.
module fp13_adder
  import fp13_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [12:0] a_i,
  input  logic [12:0] b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [12:0] sum_o,
  output logic        overflow_o
);

  fp13_add_state_e  state;
  fp13_t            big_op, sml_op, result;
  fp13_t            ca, cb;
  logic [SIG_W:0]   sum9;
  logic [EXP_W-1:0] wexp;
  logic             wsign;
  logic             ovf;
  logic [EXP_W-1:0] shift_d;

  logic             norm_done;
  logic             norm_ovf;
  fp13_t            norm_res;
  logic [SIG_W:0]   sum_nx;
  logic [EXP_W-1:0] exp_nx;

  assign ca      = fp13_canon(fp13_t'(a_i));
  assign cb      = fp13_canon(fp13_t'(b_i));
  assign shift_d = big_op.exp - sml_op.exp;

`ifdef FP13_ADDER_LZC_EN
  logic [3:0] lz;

  fp13_lzc u_lzc (
    .val (sum9[SIG_W-1:0]),
    .cnt (lz)
  );
`endif

  always_comb begin
    norm_done = 1'b1;
    norm_ovf  = 1'b0;
    norm_res  = '0;
    sum_nx    = sum9;
    exp_nx    = wexp;
    if (sum9 == '0) begin
      norm_res = '0;
    end else if (sum9[SIG_W]) begin
      if (wexp == EXP_MAX) begin
        norm_res = {wsign, EXP_MAX, 8'hFF};
        norm_ovf = 1'b1;
      end else begin
        norm_res = {wsign, wexp + 4'd1, sum9[SIG_W:1]};
      end
    end else if (sum9[SIG_W-1]) begin
      norm_res = {wsign, wexp, sum9[SIG_W-1:0]};
    end else begin
`ifdef FP13_ADDER_LZC_EN
      // Needing more left shifts than the exponent allows means underflow.
      if (lz > wexp) norm_res = '0;
      else           norm_res = {wsign, wexp - lz, 8'(sum9[SIG_W-1:0] << lz)};
`else
      if (wexp == '0) begin
        norm_res = '0;
      end else begin
        norm_done = 1'b0;
        sum_nx    = {sum9[SIG_W-1:0], 1'b0};
        exp_nx    = wexp - 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      big_op <= '0;
      sml_op <= '0;
      sum9   <= '0;
      wexp   <= '0;
      wsign  <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            // Ties keep A as the larger operand.
            if ({ca.exp, ca.sig} >= {cb.exp, cb.sig}) begin
              big_op <= ca;
              sml_op <= cb;
            end else begin
              big_op <= cb;
              sml_op <= ca;
            end
            state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          sml_op.sig <= (shift_d >= 4'd8) ? '0 : (sml_op.sig >> shift_d);
          state      <= ST_ADD;
        end
        ST_ADD: begin
          if (big_op.sign == sml_op.sign) sum9 <= {1'b0, big_op.sig} + {1'b0, sml_op.sig};
          else                            sum9 <= {1'b0, big_op.sig} - {1'b0, sml_op.sig};
          wexp  <= big_op.exp;
          wsign <= big_op.sign;
          state <= ST_NORM;
        end
        ST_NORM: begin
          if (norm_done) begin
            result <= norm_res;
            ovf    <= norm_ovf;
            state  <= ST_DONE;
          end else begin
            sum9 <= sum_nx;
            wexp <= exp_nx;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            ovf   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == ST_IDLE);
  assign out_valid_o = (state == ST_DONE);
  assign sum_o       = result;
  assign overflow_o  = ovf;

endmodule

// File: tb/tb_fp13_adder.sv
// Directed-vector bench for fp13_adder: results, latency, handoff, backpressure, reset abort.
module tb_fp13_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] a_in, b_in;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] sum;
  logic        overflow;

  int n_vec  = 0;
  int n_fail = 0;

`ifdef FP13_ADDER_LZC_EN
  localparam bit LZC = 1'b1;
`else
  localparam bit LZC = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [12:0] a;
    logic [12:0] b;
    logic [12:0] sum;
    logic        ovf;
    int          lat;
    int          lat_lzc;
  } vec_t;

  vec_t vecs[12];

  fp13_adder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a_in),
    .b_i         (b_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_vec(input vec_t v);
    int lat;
    int exp_lat;
    exp_lat  = LZC ? v.lat_lzc : v.lat;
    a_in     = v.a;
    b_in     = v.b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({v.name, "_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, "_lat"}, lat, exp_lat);
    chk({v.name, "_sum"}, 32'(sum), 32'(v.sum));
    chk({v.name, "_ovf"}, 32'(overflow), 32'(v.ovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({v.name, "_rdy_after"}, 32'(in_ready), 32'd1);
    chk({v.name, "_vld_after"}, 32'(out_valid), 32'd0);
    chk({v.name, "_ovf_after"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"add_3_5",      13'h02C0, 13'h03A0, 13'h0480, 1'b0, 3, 3};
    vecs[1]  = '{"sub_5_3",      13'h03A0, 13'h12C0, 13'h0280, 1'b0, 4, 3};
    vecs[2]  = '{"sub_8_7",      13'h0480, 13'h13E0, 13'h0180, 1'b0, 6, 3};
    vecs[3]  = '{"cancel",       13'h02C0, 13'h12C0, 13'h0000, 1'b0, 3, 3};
    vecs[4]  = '{"zero_a",       13'h0000, 13'h01A0, 13'h01A0, 1'b0, 3, 3};
    vecs[5]  = '{"overflow",     13'h0FFF, 13'h0FFF, 13'h0FFF, 1'b1, 3, 3};
    vecs[6]  = '{"uflow_exp0",   13'h00C0, 13'h10A0, 13'h0000, 1'b0, 3, 3};
    vecs[7]  = '{"uflow_shift",  13'h01C0, 13'h11A0, 13'h0000, 1'b0, 4, 3};
    vecs[8]  = '{"neg_big_b",    13'h01A0, 13'h1480, 13'h13D8, 1'b0, 4, 3};
    vecs[9]  = '{"align_d8",     13'h0880, 13'h00FF, 13'h0880, 1'b0, 3, 3};
    vecs[10] = '{"neg_zeros",    13'h1000, 13'h1000, 13'h0000, 1'b0, 3, 3};
    vecs[11] = '{"trunc_carry",  13'h03FF, 13'h00FF, 13'h048F, 1'b0, 3, 3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: result held while the consumer stalls, new requests ignored.
    a_in     = 13'h02C0;
    b_in     = 13'h03A0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a_in = 13'h0FFF;
    b_in = 13'h0FFF;
    begin
      int w;
      w = 0;
      while (!out_valid && w < 40) begin
        @(posedge clk); #1;
        w++;
      end
      chk("bp_lat", w, 3);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_sum",      32'(sum),       32'h480);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_ovf",      32'(overflow),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ready_after", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1 chk("bp_no_ghost", 32'(out_valid), 32'd0);
    chk("bp_sum_kept", 32'(sum), 32'h480);

    // Reset while normalizing aborts the operation.
    a_in     = 13'h0480;
    b_in     = 13'h13E0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("nrst_in_ready",  32'(in_ready),  32'd1);
    chk("nrst_out_valid", 32'(out_valid), 32'd0);
    chk("nrst_sum",       32'(sum),       32'd0);
    repeat (8) @(posedge clk);
    #1 chk("nrst_no_result", 32'(out_valid), 32'd0);

    // Still functional after the abort.
    run_vec(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
